sent_cfg_sched: RTL and testbench

- Per-channel configuration scheduler between the SENT parameter-frame decoder and the SENT frame-generator channels.
- Captures every decoded configuration into a one-deep shadow slot for its channel.
- Releases a pending configuration to its channel only at a frame boundary, so no frame is ever generated with mixed parameters.
- Serves the channels round-robin on the shared configuration broadcast bus.

---
 rtl/sent_cfg_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_sent_cfg_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sent_cfg_sched.sv
// sent_cfg_sched
//   Per-channel configuration scheduler between the SENT parameter-frame
//   decoder and the SENT frame-generator channels. Each decoded configuration
//   goes into a one-deep shadow slot for its channel, and newer data
//   overwrites older pending data. A slot is broadcast only while its channel
//   reports ready (idle or between frames), so a frame never mixes parameters.
//   Channels are served round-robin on the shared broadcast bus.
//
// Parameters
//   SENT_NUM  number of channels served (1..32)
//   CFG_W     packed configuration width
//
// Ports
//   clk              block clock
//   rst              asynchronous reset, active-low
//   in_cfg_vld       one-cycle strobe from the decoder
//   in_cfg_channel   target channel of the strobe
//   in_cfg_data      packed configuration word
//   ch_ready         per-channel level, high = idle or between frames
//   out_cfg_vld      one-cycle broadcast strobe
//   out_cfg_channel  channel addressed by the broadcast (held between strobes)
//   out_cfg_data     configuration delivered (held between strobes)
//   pending          per-channel "slot holds an unissued configuration"
//   drop_err         sticky, a strobe addressed a channel >= SENT_NUM
//
// Optional build macro SENT_CFG_SCHED_STATS_EN adds:
//   stats_clr        synchronous clear of both counters (clear wins)
//   issue_cnt        saturating count of issued configurations
//   ovwr_cnt         saturating count of pending slots overwritten before issue
//
// FSM states (one-hot)
//   state   | meaning
//   IDLE    | wait for a channel that is both pending and ready
//   SEARCH  | rotate-priority pick starting at rr_ptr, register sel
//   ISSUE   | broadcast slot[sel] for one cycle, clear pending[sel]
//   GAP     | one forced low cycle between broadcasts

module sent_cfg_sched #(
    parameter int SENT_NUM = 1,
    parameter int CFG_W    = 66
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_cfg_vld,
    input  logic [7:0]          in_cfg_channel,
    input  logic [CFG_W-1:0]    in_cfg_data,
    input  logic [SENT_NUM-1:0] ch_ready,
`ifdef SENT_CFG_SCHED_STATS_EN
    input  logic                stats_clr,
    output logic [15:0]         issue_cnt,
    output logic [15:0]         ovwr_cnt,
`endif
    output logic                out_cfg_vld,
    output logic [7:0]          out_cfg_channel,
    output logic [CFG_W-1:0]    out_cfg_data,
    output logic [SENT_NUM-1:0] pending,
    output logic                drop_err
);

    localparam int         PTR_W  = (SENT_NUM > 1) ? $clog2(SENT_NUM) : 1;
    localparam int         SLOT_N = 1 << PTR_W;
    localparam logic [8:0] NUM_CH = 9'(SENT_NUM);
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(SENT_NUM - 1);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_SEARCH = 4'b0010,
        ST_ISSUE  = 4'b0100,
        ST_GAP    = 4'b1000
    } state_t;

    state_t state;
    state_t state_nxt;

    // Slot array is padded to a power of two so the index width is exact;
    // entries at or above SENT_NUM are never written or read.
    logic [CFG_W-1:0]    slot [SLOT_N];

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    sel;
    logic [7:0]          chan_hold;
    logic [CFG_W-1:0]    data_hold;

    logic                cap_ok;
    logic [PTR_W-1:0]    cap_idx;
    logic [SENT_NUM-1:0] cap_set;
    logic [SENT_NUM-1:0] issue_clr;
    logic [SENT_NUM-1:0] cand;
    logic                any_cand;
    logic                is_issue;

    logic                hi_found;
    logic [PTR_W-1:0]    hi_sel;
    logic [PTR_W-1:0]    lo_sel;
    logic [PTR_W-1:0]    cand_sel;

    assign cap_ok   = in_cfg_vld && ({1'b0, in_cfg_channel} < NUM_CH);
    assign cap_idx  = in_cfg_channel[PTR_W-1:0];
    assign cand     = pending & ch_ready;
    assign any_cand = |cand;
    assign is_issue = (state == ST_ISSUE);

    // Rotating priority: the lowest candidate at or above rr_ptr wins,
    // otherwise wrap to the lowest candidate overall.
    always_comb begin
        hi_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int i = SENT_NUM - 1; i >= 0; i--) begin
            if (cand[i]) begin
                lo_sel = PTR_W'(i);
                if (PTR_W'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_sel   = PTR_W'(i);
                end
            end
        end
        cand_sel = hi_found ? hi_sel : lo_sel;
    end

    // Clear is applied before set, so a capture landing on the channel being
    // issued keeps it pending with the newer data.
    always_comb begin
        issue_clr = '0;
        cap_set   = '0;
        for (int i = 0; i < SENT_NUM; i++) begin
            issue_clr[i] = is_issue && (sel == PTR_W'(i));
            cap_set[i]   = cap_ok && (in_cfg_channel == 8'(i));
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (any_cand) state_nxt = ST_SEARCH;
            // ch_ready may have dropped since IDLE looked at it.
            ST_SEARCH: state_nxt = any_cand ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:  state_nxt = ST_GAP;
            ST_GAP:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output logic. The broadcast word reads the slot live during ISSUE so a
    // capture for the selected channel during SEARCH is not lost; outside
    // ISSUE the last broadcast is held.
    always_comb begin
        out_cfg_vld     = 1'b0;
        out_cfg_channel = chan_hold;
        out_cfg_data    = data_hold;
        if (is_issue) begin
            out_cfg_vld     = 1'b1;
            out_cfg_channel = {{(8 - PTR_W){1'b0}}, sel};
            out_cfg_data    = slot[sel];
        end
    end

    always_ff @(posedge clk) begin
        if (cap_ok) begin
            slot[cap_idx] <= in_cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending   <= '0;
            rr_ptr    <= '0;
            sel       <= '0;
            chan_hold <= '0;
            data_hold <= '0;
            drop_err  <= 1'b0;
        end else begin
            pending <= (pending & ~issue_clr) | cap_set;
            if (in_cfg_vld && !cap_ok) begin
                drop_err <= 1'b1;
            end
            if ((state == ST_SEARCH) && any_cand) begin
                sel <= cand_sel;
            end
            if (is_issue) begin
                rr_ptr    <= (sel == LAST_CH) ? '0 : sel + 1'b1;
                chan_hold <= out_cfg_channel;
                data_hold <= out_cfg_data;
            end
        end
    end

`ifdef SENT_CFG_SCHED_STATS_EN
    // An overwrite is a capture onto a slot that is still pending after this
    // cycle's issue; replacing the slot being broadcast right now is not one.
    logic ovwr_evt;
    assign ovwr_evt = |(cap_set & pending & ~issue_clr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt <= '0;
            ovwr_cnt  <= '0;
        end else if (stats_clr) begin
            issue_cnt <= '0;
            ovwr_cnt  <= '0;
        end else begin
            if (is_issue && (issue_cnt != 16'hFFFF)) begin
                issue_cnt <= issue_cnt + 16'd1;
            end
            if (ovwr_evt && (ovwr_cnt != 16'hFFFF)) begin
                ovwr_cnt <= ovwr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sent_cfg_sched.sv
module tb_sent_cfg_sched;

    localparam int N = 4;
    localparam int W = 66;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_cfg_vld = 1'b0;
    logic [7:0]    in_cfg_channel = '0;
    logic [W-1:0]  in_cfg_data = '0;
    logic [N-1:0]  ch_ready = '1;
    logic          out_cfg_vld;
    logic [7:0]    out_cfg_channel;
    logic [W-1:0]  out_cfg_data;
    logic [N-1:0]  pending;
    logic          drop_err;
`ifdef SENT_CFG_SCHED_STATS_EN
    logic          stats_clr = 1'b0;
    logic [15:0]   issue_cnt;
    logic [15:0]   ovwr_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sent_cfg_sched #(.SENT_NUM(N), .CFG_W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_cfg_vld     (in_cfg_vld),
        .in_cfg_channel (in_cfg_channel),
        .in_cfg_data    (in_cfg_data),
        .ch_ready       (ch_ready),
`ifdef SENT_CFG_SCHED_STATS_EN
        .stats_clr      (stats_clr),
        .issue_cnt      (issue_cnt),
        .ovwr_cnt       (ovwr_cnt),
`endif
        .out_cfg_vld    (out_cfg_vld),
        .out_cfg_channel(out_cfg_channel),
        .out_cfg_data   (out_cfg_data),
        .pending        (pending),
        .drop_err       (drop_err)
    );

    function automatic logic [W-1:0] rnd_cfg();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // Observe up to max_cyc negedges; stops at the first broadcast strobe.
    // lat = number of negedges until the strobe, -1 on timeout.
    task automatic wait_issue(input int max_cyc, output int lat,
                              output logic [7:0] ch, output logic [W-1:0] d);
        lat = -1;
        ch  = '0;
        d   = '0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            in_cfg_vld = 1'b0;
            if (out_cfg_vld === 1'b1) begin
                lat = k;
                ch  = out_cfg_channel;
                d   = out_cfg_data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_cfg_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b exp=0", out_cfg_vld); end
        checks++; if (pending !== '0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending); end
        checks++; if (out_cfg_channel !== 8'd0) begin failures++; $display("FAIL reset_channel got=%0d exp=0", out_cfg_channel); end
        checks++; if (out_cfg_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_cfg_data); end
        checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL reset_drop got=%0b exp=0", drop_err); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_issue();
        int lat; logic [7:0] ch; logic [W-1:0] d;
        ch_ready = 4'hF;
        in_cfg_vld = 1'b1; in_cfg_channel = 8'd2; in_cfg_data = 66'h1;
        @(negedge clk);
        in_cfg_vld = 1'b0;
        checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL single_pending_set got=%b exp=0100", pending); end
        wait_issue(8, lat, ch, d);
        lat = (lat < 0) ? lat : lat + 1;
        checks++; if (lat != 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", lat); end
        checks++; if (ch !== 8'd2) begin failures++; $display("FAIL single_channel got=%0d exp=2", ch); end
        checks++; if (d !== 66'h1) begin failures++; $display("FAIL single_data got=%h exp=1", d); end
        @(negedge clk);
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL single_pending_clr got=%b exp=0000", pending); end
        checks++; if (out_cfg_vld !== 1'b0) begin failures++; $display("FAIL single_one_cycle got=%0b exp=0", out_cfg_vld); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_not_ready();
        int lat; logic [7:0] ch; logic [W-1:0] d; logic [W-1:0] x;
        x = rnd_cfg();
        ch_ready = 4'b1101;
        in_cfg_vld = 1'b1; in_cfg_channel = 8'd1; in_cfg_data = x;
        wait_issue(8, lat, ch, d);
        checks++; if (lat != -1) begin failures++; $display("FAIL notready_no_issue got=%0d exp=-1", lat); end
        checks++; if (pending !== 4'b0010) begin failures++; $display("FAIL notready_pending got=%b exp=0010", pending); end
        ch_ready = 4'hF;
        wait_issue(8, lat, ch, d);
        checks++; if (lat != 2) begin failures++; $display("FAIL notready_latency got=%0d exp=2", lat); end
        checks++; if (ch !== 8'd1) begin failures++; $display("FAIL notready_channel got=%0d exp=1", ch); end
        checks++; if (d !== x) begin failures++; $display("FAIL notready_data got=%h exp=%h", d, x); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc_q[$]; logic [7:0] ch_q[$]; logic [W-1:0] d_q[$];
        logic [7:0] exp_ch [3];
        logic [W-1:0] exp_d [3];
        exp_ch = '{8'd0, 8'd1, 8'd3};
        for (int i = 0; i < 3; i++) exp_d[i] = rnd_cfg();
        ch_ready = 4'hF;
        in_cfg_vld = 1'b1; in_cfg_channel = exp_ch[0]; in_cfg_data = exp_d[0];
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 1) begin in_cfg_channel = exp_ch[1]; in_cfg_data = exp_d[1]; end
            else if (k == 2) begin in_cfg_channel = exp_ch[2]; in_cfg_data = exp_d[2]; end
            else in_cfg_vld = 1'b0;
            if (out_cfg_vld === 1'b1) begin
                cyc_q.push_back(k); ch_q.push_back(out_cfg_channel); d_q.push_back(out_cfg_data);
            end
        end
        checks++; if (cyc_q.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", cyc_q.size()); end
        if (cyc_q.size() == 3) begin
            checks++; if (cyc_q[0] != 3) begin failures++; $display("FAIL b2b_first_cycle got=%0d exp=3", cyc_q[0]); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (ch_q[i] !== exp_ch[i]) begin failures++; $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, ch_q[i], exp_ch[i]); end
                checks++; if (d_q[i] !== exp_d[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, d_q[i], exp_d[i]); end
            end
            for (int i = 1; i < 3; i++) begin
                checks++; if (cyc_q[i] - cyc_q[i-1] != 4) begin failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=4", i, cyc_q[i] - cyc_q[i-1]); end
            end
        end
    endtask

    task automatic test_overwrite();
        int lat; logic [7:0] ch; logic [W-1:0] d; logic [W-1:0] a, b;
        a = rnd_cfg();
        b = rnd_cfg();
        ch_ready = 4'b0111;
        in_cfg_vld = 1'b1; in_cfg_channel = 8'd3; in_cfg_data = a;
        @(negedge clk);
        in_cfg_data = b;
        wait_issue(6, lat, ch, d);
        checks++; if (lat != -1) begin failures++; $display("FAIL ovwr_no_issue got=%0d exp=-1", lat); end
        checks++; if (pending !== 4'b1000) begin failures++; $display("FAIL ovwr_pending got=%b exp=1000", pending); end
`ifdef SENT_CFG_SCHED_STATS_EN
        checks++; if (ovwr_cnt !== 16'd1) begin failures++; $display("FAIL ovwr_cnt got=%0d exp=1", ovwr_cnt); end
`endif
        ch_ready = 4'hF;
        wait_issue(8, lat, ch, d);
        checks++; if (lat != 2) begin failures++; $display("FAIL ovwr_latency got=%0d exp=2", lat); end
        checks++; if (ch !== 8'd3) begin failures++; $display("FAIL ovwr_channel got=%0d exp=3", ch); end
        checks++; if (d !== b) begin failures++; $display("FAIL ovwr_data got=%h exp=%h", d, b); end
        wait_issue(10, lat, ch, d);
        checks++; if (lat != -1) begin failures++; $display("FAIL ovwr_single_issue got=%0d exp=-1", lat); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL ovwr_pending_clr got=%b exp=0000", pending); end
`ifdef SENT_CFG_SCHED_STATS_EN
        checks++; if (issue_cnt !== 16'd6) begin failures++; $display("FAIL issue_cnt got=%0d exp=6", issue_cnt); end
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        checks++; if (issue_cnt !== 16'd0 || ovwr_cnt !== 16'd0) begin failures++; $display("FAIL stats_clr got=%0d/%0d exp=0/0", issue_cnt, ovwr_cnt); end
`endif
    endtask

    task automatic test_drop();
        int lat; logic [7:0] ch; logic [W-1:0] d;
        in_cfg_vld = 1'b1; in_cfg_channel = 8'd7; in_cfg_data = rnd_cfg();
        @(negedge clk);
        in_cfg_vld = 1'b0;
        checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL drop_set got=%0b exp=1", drop_err); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL drop_pending got=%b exp=0000", pending); end
        wait_issue(6, lat, ch, d);
        checks++; if (lat != -1) begin failures++; $display("FAIL drop_no_issue got=%0d exp=-1", lat); end
        checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL drop_sticky got=%0b exp=1", drop_err); end
    endtask

    task automatic test_reset_mid_issue();
        int lat; logic [7:0] ch; logic [W-1:0] d;
        ch_ready = 4'hF;
        in_cfg_vld = 1'b1; in_cfg_channel = 8'd0; in_cfg_data = rnd_cfg();
        @(negedge clk);
        in_cfg_channel = 8'd2; in_cfg_data = rnd_cfg();
        wait_issue(8, lat, ch, d);
        checks++; if (lat != 2) begin failures++; $display("FAIL rstmid_reach_issue got=%0d exp=2", lat); end
        rst = 1'b0;
        #1;
        checks++; if (out_cfg_vld !== 1'b0) begin failures++; $display("FAIL rstmid_vld got=%0b exp=0", out_cfg_vld); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL rstmid_pending got=%b exp=0000", pending); end
        checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL rstmid_drop got=%0b exp=0", drop_err); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Randomized traffic against a set/queue level model: last-writer-wins
    // slots, pending set, round-robin pointer advanced past each issued channel.
    task automatic test_random();
        logic [W-1:0] m_slot [N];
        logic [N-1:0] m_pend, pend_prev, cur;
        logic         m_drop;
        int           m_rr, last_issue, exp_ch, got_ch, c;
        m_pend = '0; pend_prev = '0; m_drop = 1'b0; m_rr = 0; last_issue = -100;
        for (int i = 0; i < N; i++) m_slot[i] = '0;
        ch_ready = 4'hF;
        in_cfg_vld = 1'b0;
        for (int cyc = 0; cyc < 440; cyc++) begin
            @(negedge clk);
            cur = m_pend;
            checks++; if (pending !== cur) begin failures++; $display("FAIL rnd_pending cyc=%0d got=%b exp=%b", cyc, pending, cur); end
            checks++; if (drop_err !== m_drop) begin failures++; $display("FAIL rnd_drop cyc=%0d got=%0b exp=%0b", cyc, drop_err, m_drop); end
            if (out_cfg_vld === 1'b1) begin
                exp_ch = -1;
                for (int j = 0; j < N; j++) begin
                    if (exp_ch < 0 && pend_prev[(m_rr + j) % N]) exp_ch = (m_rr + j) % N;
                end
                got_ch = int'(out_cfg_channel);
                checks++; if (got_ch != exp_ch) begin failures++; $display("FAIL rnd_rr cyc=%0d got=%0d exp=%0d", cyc, got_ch, exp_ch); end
                checks++; if (cyc - last_issue < 4) begin failures++; $display("FAIL rnd_spacing cyc=%0d got=%0d exp>=4", cyc, cyc - last_issue); end
                if (got_ch >= 0 && got_ch < N) begin
                    checks++; if (out_cfg_data !== m_slot[got_ch]) begin failures++; $display("FAIL rnd_data cyc=%0d ch=%0d got=%h exp=%h", cyc, got_ch, out_cfg_data, m_slot[got_ch]); end
                    m_pend[got_ch] = 1'b0;
                    m_rr = (got_ch + 1) % N;
                end
                last_issue = cyc;
            end
            pend_prev = cur;
            in_cfg_vld = 1'b0;
            if (cyc < 400 && $urandom_range(0, 2) == 0) begin
                c = int'($urandom_range(0, 5));
                in_cfg_vld = 1'b1;
                in_cfg_channel = 8'(c);
                in_cfg_data = rnd_cfg();
                if (c < N) begin
                    m_slot[c] = in_cfg_data;
                    m_pend[c] = 1'b1;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL rnd_drain got=%b exp=0000", pending); end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_not_ready();
        test_back_to_back();
        test_overwrite();
        test_drop();
        test_reset_mid_issue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
